// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// parity modes and the majority-vote helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversampling tick generator; one-clk tick every DIV clocks,
// phase realigned by restart.
module uart_baud_tick #(
    parameter int unsigned CLOCK_FREQ = 38400000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Parametrised oversampling UART receiver with majority-vote sampling,
// frame/parity/break detection and a small output FIFO.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 38400000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 soft_reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun_err,
    output logic                 break_det
);

    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned W   = DATA_BITS + 2;

    localparam logic [OSW-1:0] IDX_LO   = OSW'(OVERSAMPLE / 2 - 1);
    localparam logic [OSW-1:0] IDX_MID  = OSW'(OVERSAMPLE / 2);
    localparam logic [OSW-1:0] IDX_HI   = OSW'(OVERSAMPLE / 2 + 1);
    localparam logic [OSW-1:0] IDX_LAST = OSW'(OVERSAMPLE - 1);

    logic rx_m, rx_s;
    logic tick, restart;
    rx_state_t state, nxt;

    logic [OSW-1:0]       os_cnt;
    logic                 s0, s1, vote, vote_evt;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic                 par_bit, par_err, frame_acc;
    logic                 push, brk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    uart_baud_tick #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             state <= ST_IDLE;
        else if (soft_reset) state <= ST_IDLE;
        else                 state <= nxt;
    end

    // The vote completes on the tick after mid-bit, once all three samples exist.
    always_comb begin
        nxt      = state;
        restart  = 1'b0;
        push     = 1'b0;
        brk      = 1'b0;
        vote     = maj3(s0, s1, rx_s);
        vote_evt = tick && (os_cnt == IDX_HI);
        par_err  = 1'b0;
        if (PARITY == PARITY_ODD)       par_err = (par_bit == ^shreg);
        else if (PARITY == PARITY_EVEN) par_err = (par_bit != ^shreg);
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    restart = 1'b1;
                    nxt     = ST_START;
                end
            end
            ST_START: begin
                if (vote_evt) nxt = vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (vote_evt && bit_cnt == 4'(DATA_BITS - 1))
                    nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (vote_evt) nxt = ST_STOP;
            end
            ST_STOP: begin
                if (vote_evt) begin
                    if (bit_cnt == '0 && !vote && shreg == '0 && !par_bit) begin
                        nxt = ST_BREAK;
                        brk = 1'b1;
                    end else if (bit_cnt == 4'(STOP_BITS - 1)) begin
                        push = 1'b1;
                        nxt  = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) nxt = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            os_cnt    <= '0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            frame_acc <= 1'b0;
        end else begin
            if (restart)   os_cnt <= OSW'(1);
            else if (tick) os_cnt <= (os_cnt == IDX_LAST) ? '0 : os_cnt + OSW'(1);
            if (tick && os_cnt == IDX_LO)  s0 <= rx_s;
            if (tick && os_cnt == IDX_MID) s1 <= rx_s;
            if (vote_evt) begin
                case (state)
                    ST_START: begin
                        bit_cnt   <= '0;
                        par_bit   <= 1'b0;
                        frame_acc <= 1'b0;
                    end
                    ST_DATA: begin
                        shreg   <= {vote, shreg[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == 4'(DATA_BITS - 1)) ? '0 : bit_cnt + 4'd1;
                    end
                    ST_PARITY: par_bit <= vote;
                    ST_STOP: begin
                        bit_cnt   <= bit_cnt + 4'd1;
                        frame_acc <= frame_acc | ~vote;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             break_det <= 1'b0;
        else if (soft_reset) break_det <= 1'b0;
        else                 break_det <= brk;
    end

    logic [W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]  wr_ptr, rd_ptr;
    logic         empty, full, pop, wr_en;
    logic [W-1:0] head;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && rx_ready;
    // A full FIFO still accepts a push when the head leaves in the same clk.
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overrun_err <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overrun_err <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && full && !pop) overrun_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !soft_reset)
            mem[wr_ptr[AW-1:0]] <= {frame_acc | ~vote, par_err, shreg};
    end

    assign head          = mem[rd_ptr[AW-1:0]];
    assign rx_valid      = !empty;
    assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid & head[DATA_BITS];
    assign rx_frame_err  = rx_valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 and an 8E1 instance driven with
// hand-built serial frames, popped words captured and compared.
module tb_uart_rx_os;

    localparam int BIT = 160;

    logic clk = 1'b0;
    logic rst, soft_reset;
    logic rx_n, rx_e, ready_n, ready_e;
    logic [7:0] data_n, data_e;
    logic fe_n, pe_n, valid_n, ovr_n, brkd_n;
    logic fe_e, pe_e, valid_e, ovr_e, brkd_e;

    always #5 clk = ~clk;

    uart_rx_os #(
        .CLOCK_FREQ (16000000), .BAUD_RATE (100000), .OVERSAMPLE (16),
        .DATA_BITS (8), .PARITY (0), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) dut_n (
        .clk (clk), .rst (rst), .soft_reset (soft_reset), .rx (rx_n),
        .rx_data (data_n), .rx_frame_err (fe_n), .rx_parity_err (pe_n),
        .rx_valid (valid_n), .rx_ready (ready_n), .overrun_err (ovr_n),
        .break_det (brkd_n)
    );

    uart_rx_os #(
        .CLOCK_FREQ (16000000), .BAUD_RATE (100000), .OVERSAMPLE (16),
        .DATA_BITS (8), .PARITY (2), .STOP_BITS (1), .FIFO_DEPTH (4)
    ) dut_e (
        .clk (clk), .rst (rst), .soft_reset (soft_reset), .rx (rx_e),
        .rx_data (data_e), .rx_frame_err (fe_e), .rx_parity_err (pe_e),
        .rx_valid (valid_e), .rx_ready (ready_e), .overrun_err (ovr_e),
        .break_det (brkd_e)
    );

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } cap_t;

    typedef struct {
        bit         even;
        logic [7:0] d;
        logic       pbit;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    cap_t q_n[$];
    cap_t q_e[$];
    cap_t c_n, c_e;
    int   brk_n, brk_e;
    int   errors = 0;
    int   checks = 0;

    always @(negedge clk) begin
        if (valid_n && ready_n) begin
            c_n.d = data_n; c_n.fe = fe_n; c_n.pe = pe_n;
            q_n.push_back(c_n);
        end
        if (valid_e && ready_e) begin
            c_e.d = data_e; c_e.fe = fe_e; c_e.pe = pe_e;
            q_e.push_back(c_e);
        end
        if (brkd_n) brk_n++;
        if (brkd_e) brk_e++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit even, input logic v);
        if (even) rx_e = v;
        else      rx_n = v;
        repeat (BIT) @(posedge clk);
    endtask

    task automatic send_frame(input bit even, input logic [7:0] d, input logic pbit, input logic stop);
        drive(even, 1'b0);
        for (int i = 0; i < 8; i++) drive(even, d[i]);
        if (even) drive(even, pbit);
        drive(even, stop);
        drive(even, 1'b1);
    endtask

    task automatic wait_q(input bit even, input int n);
        for (int k = 0; k < 400; k++) begin
            if ((even ? q_e.size() : q_n.size()) >= n) break;
            @(posedge clk);
        end
    endtask

    task automatic pulse_soft_reset();
        @(negedge clk) soft_reset = 1'b1;
        @(negedge clk) soft_reset = 1'b0;
    endtask

    task automatic check_one_n(input string name, input logic [7:0] d);
        wait_q(1'b0, 1);
        chk({name, " count"}, q_n.size(), 1);
        if (q_n.size() > 0) begin
            chk({name, " data"}, q_n[0].d, d);
            chk({name, " fe"}, q_n[0].fe, 1'b0);
            chk({name, " pe"}, q_n[0].pe, 1'b0);
        end
    endtask

    vec_t vecs[9];
    cap_t got;
    int   sz;

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};

        rst = 1'b1; soft_reset = 1'b0;
        rx_n = 1'b1; rx_e = 1'b1; ready_n = 1'b1; ready_e = 1'b1;
        brk_n = 0; brk_e = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset outs n", {data_n, fe_n, pe_n, valid_n, ovr_n, brkd_n}, 0);
        chk("reset outs e", {data_e, fe_e, pe_e, valid_e, ovr_e, brkd_e}, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        for (int i = 0; i < 9; i++) begin
            q_n.delete(); q_e.delete(); brk_n = 0; brk_e = 0;
            send_frame(vecs[i].even, vecs[i].d, vecs[i].pbit, vecs[i].stop);
            wait_q(vecs[i].even, 1);
            sz = vecs[i].even ? q_e.size() : q_n.size();
            chk($sformatf("vec%0d count", i), sz, 1);
            if (sz > 0) begin
                got = vecs[i].even ? q_e[0] : q_n[0];
                chk($sformatf("vec%0d data", i), got.d, vecs[i].exp_d);
                chk($sformatf("vec%0d fe", i), got.fe, vecs[i].exp_fe);
                chk($sformatf("vec%0d pe", i), got.pe, vecs[i].exp_pe);
            end
            chk($sformatf("vec%0d no break", i), brk_n + brk_e, 0);
        end

        // Short low glitch must be rejected, then a real frame follows.
        q_n.delete(); brk_n = 0;
        rx_n = 1'b0;
        repeat (30) @(posedge clk);
        rx_n = 1'b1;
        repeat (400) @(posedge clk);
        chk("glitch no push", q_n.size(), 0);
        chk("glitch no break", brk_n, 0);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        check_one_n("after glitch", 8'h3C);

        // Overrun: five words into a four-deep FIFO with no reader.
        q_n.delete(); ready_n = 1'b0;
        for (int v = 1; v <= 5; v++) send_frame(1'b0, 8'(v), 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("ovr flag", ovr_n, 1'b1);
        chk("ovr valid held", valid_n, 1'b1);
        chk("ovr head stable", data_n, 8'h01);
        ready_n = 1'b1;
        repeat (10) @(posedge clk);
        chk("ovr pop count", q_n.size(), 4);
        for (int j = 0; j < 4; j++)
            if (q_n.size() > j) chk($sformatf("ovr pop%0d", j), q_n[j].d, 8'(j + 1));
        @(negedge clk);
        chk("ovr drained", valid_n, 1'b0);
        chk("ovr sticky", ovr_n, 1'b1);
        pulse_soft_reset();
        chk("ovr cleared", ovr_n, 1'b0);

        // soft_reset empties a non-empty FIFO.
        q_n.delete(); ready_n = 1'b0;
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1);
        @(negedge clk);
        chk("sr pre valid", valid_n, 1'b1);
        chk("sr pre data", data_n, 8'h5A);
        pulse_soft_reset();
        chk("sr emptied", valid_n, 1'b0);
        ready_n = 1'b1;
        repeat (5) @(posedge clk);
        chk("sr no pop", q_n.size(), 0);

        // Line break: one pulse, no push, then normal reception.
        q_n.delete(); brk_n = 0;
        rx_n = 1'b0;
        repeat (2000) @(posedge clk);
        rx_n = 1'b1;
        repeat (400) @(posedge clk);
        chk("break pulses", brk_n, 1);
        chk("break no push", q_n.size(), 0);
        send_frame(1'b0, 8'h7E, 1'b0, 1'b1);
        check_one_n("after break", 8'h7E);

        // rst at data bit 4 of a frame, with a word already held.
        q_n.delete(); ready_n = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst pre valid", valid_n, 1'b1);
        drive(1'b0, 1'b0);
        for (int b = 0; b < 4; b++) drive(1'b0, 1'b0);
        rx_n = 1'b1;
        repeat (10) @(posedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("midframe rst outs", {data_n, fe_n, pe_n, valid_n, ovr_n, brkd_n}, 0);
        rst = 1'b0;
        ready_n = 1'b1;
        repeat (6 * BIT) @(posedge clk);
        chk("rst partial dropped", q_n.size(), 0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b1);
        check_one_n("after rst", 8'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
